// File: rtl/event_encoder_8to3.sv
// rtl/event_encoder_8to3.sv - registered 8-to-3 event encoder with valid/ready output
//
// Captures rising edges on D0..D7 into pending bits and emits one 3-bit code
// per event on {A0,A1,A2} under a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   D0..D7       request lines; a 0->1 between consecutive samples is one event
//   ready        consumer accepts the current code when high with valid
//   A0,A1,A2     code MSB..LSB, code = index of the originating D line
//   valid        code on A0..A2 is meaningful
//   ovf          sticky flag: an event arrived on an already-pending line
//
// ROUND_ROBIN = 1 searches from the index after the last transfer;
// ROUND_ROBIN = 0 always picks the lowest pending index.

module event_encoder_8to3 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    input  logic ready,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic valid,
    output logic ovf
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] code;
    logic [2:0] code_next;
    logic [2:0] last;
    logic [2:0] last_next;
    logic [2:0] start;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    logic [7:0] d_vec;
    logic [7:0] d_q;
    logic [7:0] edge_v;
    logic [7:0] pending;
    logic [7:0] pending_next;
    logic [7:0] clr_mask;
    logic       xfer;
    logic       ovf_r;

    assign d_vec    = {D7, D6, D5, D4, D3, D2, D1, D0};
    assign edge_v   = d_vec & ~d_q;
    assign xfer     = (state == HOLD) && ready;
    assign clr_mask = xfer ? (8'd1 << code) : 8'd0;

    // A fresh edge on the index leaving this cycle re-pends it.
    assign pending_next = (pending & ~clr_mask) | edge_v;

    // The code leaving this cycle already counts as "last" when picking
    // the back-to-back successor.
    assign last_next = xfer ? code : last;
    assign start     = ROUND_ROBIN ? (last_next + 3'd1) : 3'd0;

    // First set bit of pending_next, scanning upward from start with wrap.
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && pending_next[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        code_next  = code;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = HOLD;
                    code_next  = sel;
                end else begin
                    code_next  = 3'd0;
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (found) begin
                        code_next  = sel;
                    end else begin
                        state_next = IDLE;
                        code_next  = 3'd0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                code_next  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            code    <= 3'd0;
            pending <= 8'd0;
            last    <= 3'd7;
            d_q     <= 8'hFF;
            ovf_r   <= 1'b0;
        end else begin
            state   <= state_next;
            code    <= code_next;
            pending <= pending_next;
            last    <= last_next;
            d_q     <= d_vec;
            // Duplicate event on a line still waiting: merged, but flagged.
            if (|(edge_v & pending & ~clr_mask)) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign valid = (state == HOLD);
    assign A0    = code[2];
    assign A1    = code[1];
    assign A2    = code[0];
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// tb/tb_event_encoder_8to3.sv - scoreboard bench for event_encoder_8to3 (both service orders)

module tb_event_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] d_in;
    logic       ready;

    logic       a0_r, a1_r, a2_r, valid_r, ovf_r;
    logic       a0_f, a1_f, a2_f, valid_f, ovf_f;

    event_encoder_8to3 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .D0(d_in[0]), .D1(d_in[1]), .D2(d_in[2]), .D3(d_in[3]),
        .D4(d_in[4]), .D5(d_in[5]), .D6(d_in[6]), .D7(d_in[7]),
        .ready(ready), .A0(a0_r), .A1(a1_r), .A2(a2_r),
        .valid(valid_r), .ovf(ovf_r)
    );

    event_encoder_8to3 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .D0(d_in[0]), .D1(d_in[1]), .D2(d_in[2]), .D3(d_in[3]),
        .D4(d_in[4]), .D5(d_in[5]), .D6(d_in[6]), .D7(d_in[7]),
        .ready(ready), .A0(a0_f), .A1(a1_f), .A2(a2_f),
        .valid(valid_f), .ovf(ovf_f)
    );

    logic [2:0] dcode [2];
    logic       dvalid[2];
    logic       dovf  [2];
    assign dcode[0]  = {a0_r, a1_r, a2_r};
    assign dcode[1]  = {a0_f, a1_f, a2_f};
    assign dvalid[0] = valid_r;
    assign dvalid[1] = valid_f;
    assign dovf[0]   = ovf_r;
    assign dovf[1]   = ovf_f;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, unit 0 = round robin, unit 1 = fixed priority.
    bit m_pend [2][8];
    bit m_prev [2][8];
    bit m_valid[2];
    bit m_ovf  [2];
    int m_code [2];
    int m_last [2];
    int q_rr[$];
    int q_fp[$];

    function automatic int pick(int u);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (u == 0) ? (m_last[u] + k) % 8 : k - 1;
            if (m_pend[u][idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    m_pend[u][i] = 1'b0;
                    m_prev[u][i] = 1'b1;
                end
                m_valid[u] = 1'b0;
                m_ovf[u]   = 1'b0;
                m_code[u]  = 0;
                m_last[u]  = 7;
            end else begin
                bit xfer;
                int nxt;
                xfer = m_valid[u] && ready;
                if (xfer) begin
                    if (u == 0) q_rr.push_back(m_code[u]);
                    else        q_fp.push_back(m_code[u]);
                    m_last[u] = m_code[u];
                    m_pend[u][m_code[u]] = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    if (d_in[i] && !m_prev[u][i]) begin
                        if (m_pend[u][i]) m_ovf[u] = 1'b1;
                        m_pend[u][i] = 1'b1;
                    end
                    m_prev[u][i] = d_in[i];
                end
                if (!m_valid[u] || xfer) begin
                    nxt = pick(u);
                    m_valid[u] = (nxt >= 0);
                    m_code[u]  = (nxt >= 0) ? nxt : 0;
                end
            end
        end
    end

    // Monitor: cycle-level compare at negedge, transfer scoreboard after the edge.
    bit         cap_x[2];
    logic [2:0] cap_c[2];

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (dvalid[u] !== m_valid[u]) begin
                errors++;
                $display("FAIL valid[%0d] t=%0t got %0b want %0b", u, $time, dvalid[u], m_valid[u]);
            end
            checks++;
            if (dcode[u] !== 3'(m_code[u])) begin
                errors++;
                $display("FAIL code[%0d] t=%0t got %0d want %0d", u, $time, dcode[u], m_code[u]);
            end
            checks++;
            if (dovf[u] !== m_ovf[u]) begin
                errors++;
                $display("FAIL ovf[%0d] t=%0t got %0b want %0b", u, $time, dovf[u], m_ovf[u]);
            end
            cap_x[u] = (dvalid[u] === 1'b1) && ready && rst_n;
            cap_c[u] = dcode[u];
        end
    end

    always @(posedge clk) begin
        #1;
        for (int u = 0; u < 2; u++) begin
            if (cap_x[u]) begin
                int exp_c;
                bit have;
                checks++;
                have = (u == 0) ? (q_rr.size() > 0) : (q_fp.size() > 0);
                if (!have) begin
                    errors++;
                    $display("FAIL xfer[%0d] t=%0t got code %0d want no transfer", u, $time, cap_c[u]);
                end else begin
                    exp_c = (u == 0) ? q_rr.pop_front() : q_fp.pop_front();
                    if (cap_c[u] !== 3'(exp_c)) begin
                        errors++;
                        $display("FAIL xfer[%0d] t=%0t got %0d want %0d", u, $time, cap_c[u], exp_c);
                    end
                end
                cap_x[u] = 1'b0;
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d_in  = 8'h00;
        ready = 1'b1;
        step(2);
        #4;
        checks++;
        if ({valid_r, a0_r, a1_r, a2_r, ovf_r} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state got %b want 00000", {valid_r, a0_r, a1_r, a2_r, ovf_r});
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        step(2);

        // Single pulse on D5.
        d_in = 8'h20; step(1); d_in = 8'h00; step(4);

        // D0, D2, D6 together while stalled, then drain.
        ready = 1'b0;
        d_in = 8'h45; step(1); d_in = 8'h00; step(3);
        ready = 1'b1; step(5);

        // Transfer 2, then D1 and D3 together.
        d_in = 8'h04; step(1); d_in = 8'h00; step(3);
        d_in = 8'h0A; step(1); d_in = 8'h00; step(4);

        // Duplicate D4 event while stalled.
        ready = 1'b0;
        d_in = 8'h10; step(1); d_in = 8'h00; step(1);
        d_in = 8'h10; step(1); d_in = 8'h00; step(2);
        ready = 1'b1; step(4);

        // D3 high across reset release, then re-raised.
        rst_n = 1'b0; d_in = 8'h08; step(2);
        rst_n = 1'b1; step(3);
        d_in = 8'h00; step(1); d_in = 8'h08; step(1); d_in = 8'h00; step(3);

        // Reset while D7 is being offered.
        ready = 1'b0;
        d_in = 8'h80; step(1); d_in = 8'h00; step(2);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; ready = 1'b1; step(4);

        // Random traffic with occasional stalls and resets.
        repeat (3000) begin
            d_in  = 8'($urandom) & 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            step(1);
        end

        rst_n = 1'b1; d_in = 8'h00; ready = 1'b1;
        step(20);

        checks++;
        if (q_rr.size() != 0 || q_fp.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d outstanding want 0/0", q_rr.size(), q_fp.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
